// File: rtl/gem_link_align_if.sv
// Link bundle for gem_link_align: decoded rx word toward the aligner,
// frame payload and lock/health status back out.
interface gem_link_align_if #(
    parameter int FRAME_LEN = 4
);
    logic [7:0]                 rx_data;
    logic                       rx_charisk;
    logic                       rx_err;
    logic [7:0]                 kchar;
    logic                       kchar_valid;
    logic                       locked;
    logic                       lost_lock;
    logic [7:0]                 lock_loss_cnt;
    logic [8*(FRAME_LEN-1)-1:0] frame_data;
    logic                       frame_valid;

    modport master (
        output rx_data, rx_charisk, rx_err,
        input  kchar, kchar_valid, locked, lost_lock, lock_loss_cnt,
               frame_data, frame_valid
    );

    modport slave (
        input  rx_data, rx_charisk, rx_err,
        output kchar, kchar_valid, locked, lost_lock, lock_loss_cnt,
               frame_data, frame_valid
    );
endinterface

// File: rtl/gem_link_align.sv
// Per-fiber GEM frame aligner: finds the slot-0 K-character marker, locks with
// hysteresis and emits the frame K-character and payload. Optional macro
// GEM_KCHAR_WHITELIST_EN restricts accepted markers to BC/F7/FB/FD.
module gem_link_align #(
    parameter int FRAME_LEN     = 4,
    parameter int LOCK_FRAMES   = 8,
    parameter int UNLOCK_FRAMES = 4
) (
    input  logic           clock,
    input  logic           reset,
    gem_link_align_if.slave lnk
);
    localparam int PW = 8 * (FRAME_LEN - 1);
    localparam int WW = $clog2(FRAME_LEN);
    localparam int GW = $clog2(LOCK_FRAMES + 1);
    localparam int BW = $clog2(UNLOCK_FRAMES + 1);
    localparam logic [WW-1:0] LAST_SLOT = WW'(FRAME_LEN - 1);
    localparam logic [GW-1:0] GOOD_M1   = GW'(LOCK_FRAMES - 1);
    localparam logic [BW-1:0] BAD_M1    = BW'(UNLOCK_FRAMES - 1);

    typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

    state_t        state_q, state_d;
    logic [WW-1:0] wcnt_q, wcnt_d, wcnt_nxt;
    logic [GW-1:0] good_cnt_q, good_cnt_d;
    logic [BW-1:0] bad_cnt_q, bad_cnt_d;
    logic [7:0]    kcap_q, kcap_d;
    logic          fbad_q, fbad_d;
    logic [PW-1:0] payload_q, payload_d;
    logic [7:0]    kchar_q, kchar_d;
    logic          locked_q, locked_d;
    logic          lost_lock_q, lost_lock_d;
    logic [7:0]    loss_cnt_q, loss_cnt_d;
    logic [PW-1:0] frame_data_q, frame_data_d;
    logic          frame_valid_q, frame_valid_d;
    logic          is_comma;

    always_comb begin
`ifdef GEM_KCHAR_WHITELIST_EN
        is_comma = lnk.rx_charisk && !lnk.rx_err &&
                   (lnk.rx_data inside {8'hBC, 8'hF7, 8'hFB, 8'hFD});
`else
        is_comma = lnk.rx_charisk && !lnk.rx_err;
`endif
    end

    assign wcnt_nxt = (wcnt_q == LAST_SLOT) ? '0 : wcnt_q + WW'(1);

    always_comb begin
        state_d       = state_q;
        wcnt_d        = wcnt_q;
        good_cnt_d    = good_cnt_q;
        bad_cnt_d     = bad_cnt_q;
        kcap_d        = kcap_q;
        fbad_d        = fbad_q;
        payload_d     = payload_q;
        kchar_d       = kchar_q;
        lost_lock_d   = lost_lock_q;
        loss_cnt_d    = loss_cnt_q;
        frame_data_d  = frame_data_q;
        frame_valid_d = 1'b0;

        // Frame capture runs every slot; only LOCKED consumes it at the last slot.
        if (wcnt_q == '0) begin
            kcap_d = lnk.rx_data;
            fbad_d = !is_comma;
        end else begin
            fbad_d = fbad_q || lnk.rx_err || lnk.rx_charisk;
        end
        for (int i = 1; i < FRAME_LEN; i++) begin
            if (wcnt_q == WW'(i)) payload_d[8*(i-1) +: 8] = lnk.rx_data;
        end

        case (state_q)
            SEARCH: begin
                wcnt_d = '0;
                if (is_comma) begin
                    wcnt_d     = WW'(1);
                    good_cnt_d = GW'(1);
                    state_d    = (LOCK_FRAMES == 1) ? LOCKED : VERIFY;
                end
            end
            VERIFY: begin
                wcnt_d = wcnt_nxt;
                if (wcnt_q == '0) begin
                    if (is_comma) begin
                        good_cnt_d = good_cnt_q + GW'(1);
                        if (good_cnt_q == GOOD_M1) state_d = LOCKED;
                    end else begin
                        state_d    = SEARCH;
                        wcnt_d     = '0;
                        good_cnt_d = '0;
                    end
                end else if (lnk.rx_charisk) begin
                    state_d    = SEARCH;
                    wcnt_d     = '0;
                    good_cnt_d = '0;
                end
            end
            LOCKED: begin
                wcnt_d = wcnt_nxt;
                if (wcnt_q == LAST_SLOT) begin
                    if (!fbad_d) begin
                        bad_cnt_d     = '0;
                        kchar_d       = kcap_q;
                        frame_data_d  = payload_d;
                        frame_valid_d = 1'b1;
                    end else if (bad_cnt_q == BAD_M1) begin
                        state_d     = SEARCH;
                        wcnt_d      = '0;
                        good_cnt_d  = '0;
                        bad_cnt_d   = '0;
                        kchar_d     = 8'h00;
                        lost_lock_d = 1'b1;
                        if (loss_cnt_q != 8'hFF) loss_cnt_d = loss_cnt_q + 8'd1;
                    end else begin
                        bad_cnt_d = bad_cnt_q + BW'(1);
                    end
                end
            end
            default: state_d = SEARCH;
        endcase

        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= SEARCH;
            wcnt_q        <= '0;
            good_cnt_q    <= '0;
            bad_cnt_q     <= '0;
            kcap_q        <= '0;
            fbad_q        <= 1'b0;
            payload_q     <= '0;
            kchar_q       <= 8'h00;
            locked_q      <= 1'b0;
            lost_lock_q   <= 1'b0;
            loss_cnt_q    <= 8'h00;
            frame_data_q  <= '0;
            frame_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wcnt_q        <= wcnt_d;
            good_cnt_q    <= good_cnt_d;
            bad_cnt_q     <= bad_cnt_d;
            kcap_q        <= kcap_d;
            fbad_q        <= fbad_d;
            payload_q     <= payload_d;
            kchar_q       <= kchar_d;
            locked_q      <= locked_d;
            lost_lock_q   <= lost_lock_d;
            loss_cnt_q    <= loss_cnt_d;
            frame_data_q  <= frame_data_d;
            frame_valid_q <= frame_valid_d;
        end
    end

    assign lnk.kchar         = kchar_q;
    assign lnk.kchar_valid   = locked_q;
    assign lnk.locked        = locked_q;
    assign lnk.lost_lock     = lost_lock_q;
    assign lnk.lock_loss_cnt = loss_cnt_q;
    assign lnk.frame_data    = frame_data_q;
    assign lnk.frame_valid   = frame_valid_q;
endmodule

// File: doc/gem_link_align.md
Name: gem_link_align

Overview:
- Per-fiber frame aligner for one GEM optohybrid link, directly upstream of the GEM fiber sync monitor.
- Finds the K-character frame marker in the decoded byte stream from the transceiver and holds frame lock with hysteresis.
- Outputs the per-frame K-character, which the sync monitor compares across fibers, plus the assembled frame payload and lock/health status.
- One instance per fiber (four per OTMB). Single clock domain.

Parameters:
- FRAME_LEN, 4, words per frame including the marker word; legal range >= 2.
- LOCK_FRAMES, 8, consecutive good frames required to declare lock; legal range >= 1.
- UNLOCK_FRAMES, 4, consecutive bad frames while locked that force loss of lock; legal range >= 1.

Ports:
- clock  input  1  fabric clock; one rx word per cycle.
- reset  input  1  synchronous, active-high; clock clock.
- rx_data  input  8  decoded byte from the transceiver.
- rx_charisk  input  1  rx_data is a K-character.
- rx_err  input  1  disparity or not-in-table error on this word.
- kchar  output  8  K-character of the most recent good frame; 8'h00 when not locked.
- kchar_valid  output  1  high while locked.
- locked  output  1  aligner is in LOCKED.
- lost_lock  output  1  sticky; set on any LOCKED->SEARCH transition; cleared only by reset.
- lock_loss_cnt  output  8  number of lock losses; saturates at 8'hFF.
- frame_data  output  8*(FRAME_LEN-1)  payload words of the last frame; word 1 is in the LSBs.
- frame_valid  output  1  one-cycle strobe marking that frame_data was updated.

Behaviour:
- Definitions:
  - is_comma = rx_charisk & !rx_err, further qualified by the whitelist when the optional feature is compiled in.
  - slot counter wcnt runs 0..FRAME_LEN-1 and wraps to 0; slot 0 is the marker position.
- Reset values: state=SEARCH, wcnt=0, good_cnt=0, bad_cnt=0, kchar=8'h00, kchar_valid=0, locked=0, lost_lock=0, lock_loss_cnt=0, frame_data=0, frame_valid=0.
- Reset mid-operation:
  - Returns everything to the reset values on the next edge.
  - A frame in flight is discarded; no frame_valid is issued for it.
- SEARCH:
  - wcnt is held at 0.
  - On is_comma: go to VERIFY, wcnt<=1, good_cnt<=1, capture rx_data as candidate kchar.
- VERIFY (wcnt free-running):
  - At slot 0 with is_comma: good_cnt++. When good_cnt+1 == LOCK_FRAMES, go to LOCKED.
  - At slot 0 without is_comma: go to SEARCH.
  - rx_charisk at any slot != 0: go to SEARCH (misalignment).
  - LOCK_FRAMES=1: lock is declared on the first verified comma.
- LOCKED:
  - A frame is bad if slot 0 lacks is_comma, or any payload slot has rx_err, or any payload slot has rx_charisk. A frame is counted bad at most once.
  - Evaluation occurs on the last slot (wcnt==FRAME_LEN-1).
  - Good frame: bad_cnt<=0; kchar<=captured slot-0 byte; frame_data<=captured payload; frame_valid pulses.
  - Bad frame: bad_cnt++; kchar and frame_data hold; no frame_valid.
  - When bad_cnt reaches UNLOCK_FRAMES: go to SEARCH; locked<=0, kchar_valid<=0, kchar<=8'h00; lost_lock<=1; lock_loss_cnt++ unless it is 8'hFF.
- locked and kchar_valid rise on the cycle the state register enters LOCKED.
- Latency:
  - frame_valid and the frame_data/kchar update are registered one cycle after the last slot of a frame, i.e. FRAME_LEN cycles after its marker word.
  - The first frame_valid comes from the first complete frame evaluated in LOCKED.
- Simultaneous events: if the unlock threshold is reached in the same cycle a comma arrives, the unlock wins. The comma is not re-used to start VERIFY; SEARCH begins on the following cycle.
- Wrap-around: wcnt wraps without gaps. good_cnt and bad_cnt saturate at their thresholds.

Optional Feature:
- Macro: GEM_KCHAR_WHITELIST_EN.
- Defined: is_comma additionally requires rx_data in {8'hBC (K28.5 idle), 8'hF7 (K23.7 BC0), 8'hFB (K27.7 resync), 8'hFD (K29.7 EC0)}. Any other K-character at slot 0 makes the frame bad (in VERIFY: go to SEARCH).
- Undefined: any error-free K-character at slot 0 is accepted as a marker.

Test Plan:
- Lock acquisition: FRAME_LEN=4, LOCK_FRAMES=8; drive 8'hBC K at slot 0 with payload 11,22,33 for 10 frames. Required: locked rises after the 8th marker; frame_valid each subsequent frame; frame_data=24'h332211; kchar=8'hBC.
- Unlock hysteresis: while locked, drop the marker for 3 frames, then restore it. Required: locked stays 1 and bad_cnt clears. Drop it for 4 frames: locked=0, kchar=8'h00, lost_lock=1, lock_loss_cnt=1.
- Misalignment: in VERIFY, inject a K-character at slot 2. Required: return to SEARCH, then re-lock on the new phase after 8 good frames.
- Payload error: locked, rx_err=1 on slot 1 of one frame. Required: no frame_valid for that frame, kchar held, bad_cnt=1, lock kept.
- Reset mid-frame: assert reset at wcnt=2 while locked. Required: next cycle all outputs at reset values including lost_lock=0 and lock_loss_cnt=0; no frame_valid.
- Whitelist: with GEM_KCHAR_WHITELIST_EN, send 8'h3C K markers. Required: never locks. Without the macro: locks after 8 frames with kchar=8'h3C.
